ready_timer_bank: RTL and testbench

//  Parametrised bank of N_CH independent interval timers for the intersection controller.

---
 rtl/ready_timer_bank.sv | 143 ++++++++++++++
 tb/tb_ready_timer_bank.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ready_timer_bank.sv
// Bank of N_CH interval timers: periodic/one-shot tick, sticky ready handshake, service square wave.
// Optional OVERRUN_DET_EN builds per-channel sticky overrun detection; otherwise overrun_o is tied 0.

module ready_timer_ch #(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 10,
  parameter int SVC_DIV    = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             cfg_hit_i,
  input  logic [CNT_W-1:0] cfg_period_i,
  input  logic             cfg_oneshot_i,
  input  logic             ack_i,
  output logic             tick_o,
  output logic             ready_o,
  output logic             service_o,
  output logic             overrun_o
);
  localparam int SVC_W = (SVC_DIV > 1) ? $clog2(SVC_DIV) : 1;
  localparam logic [SVC_W-1:0] SVC_LAST = SVC_W'(SVC_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d;
  logic [SVC_W-1:0] svc_q, svc_d;
  logic             os_q, os_d, arm_q, arm_d;
  logic             tick_q, tick_d, rdy_q, rdy_d, svo_q, svo_d;
  logic             ovr_q, ovr_d;
  logic             expire;

  assign expire = en_i && arm_q && (cnt_q == per_q);

  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    svc_d  = svc_q;
    os_d   = os_q;
    arm_d  = arm_q;
    tick_d = 1'b0;
    rdy_d  = rdy_q;
    svo_d  = svo_q;
    ovr_d  = ovr_q;
    if (cfg_hit_i) begin
      // reprogramming wins over expiry/ack; service level is deliberately kept
      per_d = cfg_period_i;
      os_d  = cfg_oneshot_i;
      arm_d = 1'b1;
      cnt_d = '0;
      svc_d = '0;
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end else begin
      if (en_i && arm_q) cnt_d = expire ? '0 : cnt_q + 1'b1;
      if (expire) begin
        tick_d = 1'b1;
        rdy_d  = 1'b1;
        if (os_q) arm_d = 1'b0;
        if (svc_q == SVC_LAST) begin
          svc_d = '0;
          svo_d = ~svo_q;
        end else begin
          svc_d = svc_q + 1'b1;
        end
`ifdef OVERRUN_DET_EN
        if (rdy_q && !ack_i) ovr_d = 1'b1;
`endif
      end else if (ack_i) begin
        rdy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      per_q  <= CNT_W'(DEF_PERIOD);
      svc_q  <= '0;
      os_q   <= 1'b0;
      arm_q  <= 1'b1;
      tick_q <= 1'b0;
      rdy_q  <= 1'b0;
      svo_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      svc_q  <= svc_d;
      os_q   <= os_d;
      arm_q  <= arm_d;
      tick_q <= tick_d;
      rdy_q  <= rdy_d;
      svo_q  <= svo_d;
      ovr_q  <= ovr_d;
    end
  end

  assign tick_o    = tick_q;
  assign ready_o   = rdy_q;
  assign service_o = svo_q;
`ifdef OVERRUN_DET_EN
  assign overrun_o = ovr_q;
`else
  assign overrun_o = 1'b0;
`endif
endmodule

module ready_timer_bank #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int CH_W       = 2,
  parameter int DEF_PERIOD = 10,
  parameter int SVC_DIV    = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             cfg_we_i,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [CNT_W-1:0] cfg_period_i,
  input  logic             cfg_oneshot_i,
  input  logic [N_CH-1:0]  ack_i,
  output logic [N_CH-1:0]  tick_o,
  output logic [N_CH-1:0]  ready_s_o,
  output logic [N_CH-1:0]  service_s_o,
  output logic [N_CH-1:0]  overrun_o
);
  logic [N_CH-1:0] cfg_hit;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // addresses >= N_CH match no channel, so such writes fall away
    assign cfg_hit[g] = cfg_we_i && (cfg_ch_i == CH_W'(g));

    ready_timer_ch #(
      .CNT_W(CNT_W), .DEF_PERIOD(DEF_PERIOD), .SVC_DIV(SVC_DIV)
    ) u_ch (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
      .cfg_hit_i(cfg_hit[g]), .cfg_period_i(cfg_period_i), .cfg_oneshot_i(cfg_oneshot_i),
      .ack_i(ack_i[g]),
      .tick_o(tick_o[g]), .ready_o(ready_s_o[g]),
      .service_o(service_s_o[g]), .overrun_o(overrun_o[g])
    );
  end
endmodule

// File: tb/tb_ready_timer_bank.sv
// Bench for ready_timer_bank: expiry-count model checked every cycle plus directed literal checks.
module tb_ready_timer_bank;
  localparam int N = 4, CW = 16, CHW = 2, SD = 10;
`ifdef OVERRUN_DET_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, cfg_we = 1'b0, cfg_os = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_p = '0;
  logic [N-1:0]   ack = '0, tick, rdy, svc, ovr;
  logic [2:0]     tick3, rdy3, svc3, ovr3;
  int npass = 0, ntot = 0;

  always #5 clk = ~clk;

  ready_timer_bank #(.N_CH(N), .CNT_W(CW), .CH_W(CHW), .DEF_PERIOD(10), .SVC_DIV(SD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
    .cfg_period_i(cfg_p), .cfg_oneshot_i(cfg_os), .ack_i(ack),
    .tick_o(tick), .ready_s_o(rdy), .service_s_o(svc), .overrun_o(ovr));

  // three-channel instance: cfg_ch=3 must be ignored there
  ready_timer_bank #(.N_CH(3), .CNT_W(CW), .CH_W(CHW), .DEF_PERIOD(10), .SVC_DIV(SD)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
    .cfg_period_i(cfg_p), .cfg_oneshot_i(cfg_os), .ack_i(ack[2:0]),
    .tick_o(tick3), .ready_s_o(rdy3), .service_s_o(svc3), .overrun_o(ovr3));

  // model: enabled-edge age since arm, expiry count, service level derived from expiry count
  int mp[N], mage[N], mnexp[N];
  bit mos[N], marm[N], mbase[N], mrdy[N], mtick[N], movr[N];
  bit mvalid = 1'b0;

  function automatic bit msvc(int i);
    return mbase[i] ^ (((mnexp[i] / SD) % 2) != 0);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        mp[i] = 10; mos[i] = 0; marm[i] = 1; mage[i] = 0; mnexp[i] = 0;
        mbase[i] = 0; mrdy[i] = 0; mtick[i] = 0; movr[i] = 0;
      end else if (cfg_we && int'(cfg_ch) == i) begin
        mbase[i] = msvc(i);
        mp[i] = int'(cfg_p); mos[i] = cfg_os; marm[i] = 1; mage[i] = 0; mnexp[i] = 0;
        mrdy[i] = 0; mtick[i] = 0; movr[i] = 0;
      end else begin
        bit ex;
        ex = en && marm[i] && ((mage[i] + 1) % (mp[i] + 1) == 0);
        if (en && marm[i]) mage[i]++;
        mtick[i] = ex;
        if (ex) begin
          mnexp[i]++;
          if (mos[i]) marm[i] = 0;
          if (OVR && mrdy[i] && !ack[i]) movr[i] = 1;
          mrdy[i] = 1;
        end else if (ack[i]) mrdy[i] = 0;
      end
    end
    mvalid = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    else npass++;
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      logic [N-1:0] et, er, es, eo;
      for (int i = 0; i < N; i++) begin
        et[i] = mtick[i]; er[i] = mrdy[i]; es[i] = msvc(i); eo[i] = movr[i];
      end
      chk("m_tick", 32'(tick), 32'(et));
      chk("m_ready", 32'(rdy), 32'(er));
      chk("m_service", 32'(svc), 32'(es));
      chk("m_overrun", 32'(ovr), 32'(eo));
      chk("m3_tick", 32'(tick3), 32'(et[2:0]));
      chk("m3_ready", 32'(rdy3), 32'(er[2:0]));
      chk("m3_service", 32'(svc3), 32'(es[2:0]));
      chk("m3_overrun", 32'(ovr3), 32'(eo[2:0]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int ch, input int p, input bit os);
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_p = CW'(p); cfg_os = os;
    step(1);
    cfg_we = 1'b0;
  endtask

  initial begin
    int c0, c2;
    // T1: reset defaults and first tick at edge 11
    step(2);
    chk("rst_tick", 32'(tick), 0); chk("rst_ready", 32'(rdy), 0);
    chk("rst_service", 32'(svc), 0); chk("rst_overrun", 32'(ovr), 0);
    rst_n = 1'b1;
    step(10); chk("t1_no_tick_e10", 32'(tick), 0);
    step(1);  chk("t1_tick_e11", 32'(tick), 32'hF); chk("t1_ready_e11", 32'(rdy), 32'hF);
    // T2: ack 3 cycles after tick, then ack coincident with expiry
    step(2); ack = 4'b0010;
    step(1); ack = '0; chk("t2_ack_clear", 32'(rdy), 32'hD);
    step(8); chk("t2_reassert_tick", 32'(tick), 32'hF); chk("t2_reassert_rdy", 32'(rdy), 32'hF);
    step(10); ack = 4'b0010;
    step(1); ack = '0; chk("t2_set_wins", 32'(rdy), 32'hF);
    // T3: service toggles at expiry 10 and back at 20
    step(76); chk("t3_svc_e109", 32'(svc), 0);
    step(1);  chk("t3_svc_e110", 32'(svc), 32'hF);
    step(110); chk("t3_svc_e220", 32'(svc), 0);
    // T4: one-shot ch2 with P=3
    cfg(2, 3, 1'b1);
    step(3); chk("t4_no_tick2_e224", 32'(tick[2]), 0);
    step(1); chk("t4_tick2_e225", 32'(tick[2]), 1);
    c0 = 0; c2 = 0;
    for (int k = 0; k < 100; k++) begin
      step(1); c0 += int'(tick[0]); c2 += int'(tick[2]);
    end
    chk("t4_oneshot_quiet", 32'(c2), 0);
    chk("t4_ch0_cadence", 32'(c0), 9);
    // cfg_ch=3: real channel in dut, ignored in dut3
    cfg(3, 5, 1'b0);
    step(5); chk("t4_ch3_no_tick", 32'(tick[3]), 0);
    step(1); chk("t4_ch3_tick", 32'(tick[3]), 1); chk("t4_dut3_no_ch3", 32'(tick3), 0);
    // cfg beats ack; P=0 expires every edge
    ack = 4'b0100; cfg(2, 0, 1'b0); ack = '0;
    chk("p0_cfg_clear_rdy", 32'(rdy[2]), 0);
    step(1); chk("p0_tick_a", 32'(tick[2]), 1);
    step(1); chk("p0_tick_b", 32'(tick[2]), 1);
    // T5: reset mid-count, then en=0 for 5 cycles at cnt=6
    rst_n = 1'b0; ack = '1;
    step(1);
    chk("t5_rst_tick", 32'(tick), 0); chk("t5_rst_ready", 32'(rdy), 0);
    chk("t5_rst_service", 32'(svc), 0); chk("t5_rst_overrun", 32'(ovr), 0);
    rst_n = 1'b1;
    step(3); ack = '0;
    step(3); en = 1'b0;
    step(5); en = 1'b1;
    step(4); chk("t5_no_tick_e15", 32'(tick), 0);
    step(1); chk("t5_tick_e16", 32'(tick), 32'hF); chk("t6_ovr_first", 32'(ovr), 0);
    // T6: second unacknowledged expiry raises overrun when built in
    step(11); chk("t6_ovr_second", 32'(ovr), OVR ? 32'hF : 32'h0);
    cfg(0, 10, 1'b0);
    chk("t6_ovr_cfg_clear", 32'(ovr), OVR ? 32'hE : 32'h0);
    step(20);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
